// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: N iterations per product, one per clock.
// Iteration uses add-then-shift-right on {A,Q}. The done strobe occupies the first idle cycle.
module shift_add_multiplier #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t        state;
  logic [N:0]    a_reg;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  m_reg;
  logic [CW-1:0] cnt;
  logic [N:0]    sum;

  // A never exceeds N bits after a shift, so N+1 bits hold the sum without loss.
  assign sum = a_reg + (q_reg[0] ? {1'b0, m_reg} : {(N+1){1'b0}});

  // The done cycle is already IDLE, so a waiting start is taken on the edge that
  // ends it, giving back-to-back operations every N+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= a_in;
            q_reg <= b_in;
            a_reg <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          a_reg <= {1'b0, sum[N:1]};
          q_reg <= {sum[0], q_reg[N-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            product <= {sum, q_reg[N-1:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and swept checks of shift_add_multiplier at N=6 against hand-computed products.
module tb_shift_add_multiplier;

  localparam int N = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   a_in = '0;
  logic [N-1:0]   b_in = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int vectors = 0;
  int miscompares = 0;
  int dcnt, dfirst, dlast;

  shift_add_multiplier #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Samples n falling edges; reports how many carried done and where the first/last were.
  task automatic count_dones(input int n, output int cnt, output int first, output int last);
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) begin
        if (cnt == 0) first = i;
        last = i;
        cnt++;
      end
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    logic [2*N-1:0] expv;
    int busy_w;
    int waited;
    bit seen;
    expv = (2*N)'(a) * (2*N)'(b);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
    busy_w = 0; waited = 0; seen = 1'b0;
    while (!seen && waited < 40) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_w++;
        waited++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
    check({tag, "_busy_width"}, busy_w, N);
    check({tag, "_product"}, 32'(product), 32'(expv));
    @(negedge clk);
    check({tag, "_done_single"}, 32'(done), 0);
    check({tag, "_product_held"}, 32'(product), 32'(expv));
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_product", 32'(product), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic product and timing
    run_op(6'd13, 6'd11, "t1_13x11");

    // Carry through A[N], then zero operand
    run_op(6'd63, 6'd63, "t2_63x63");
    run_op(6'd0, 6'd45, "t2_0x45");

    // Start pulsed during CALC is ignored
    @(negedge clk);
    start = 1'b1; a_in = 6'd5; b_in = 6'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a_in = 6'd2; b_in = 6'd2;
    @(negedge clk);
    start = 1'b0; a_in = '0; b_in = '0;
    count_dones(15, dcnt, dfirst, dlast);
    check("t3_ignore_done_count", dcnt, 1);
    check("t3_ignore_product", 32'(product), 35);

    // Start held for 14 cycles: two completions, N+1 apart
    start = 1'b1; a_in = 6'd5; b_in = 6'd7;
    count_dones(14, dcnt, dfirst, dlast);
    start = 1'b0;
    check("t3_held_done_count", dcnt, 2);
    check("t3_held_first_done", dfirst, N);
    check("t3_held_period", dlast - dfirst, N + 1);
    count_dones(10, dcnt, dfirst, dlast);
    check("t3_held_no_third", dcnt, 0);
    check("t3_held_product", 32'(product), 35);

    // Operands change right after acceptance
    @(negedge clk);
    start = 1'b1; a_in = 6'd9; b_in = 6'd9;
    @(negedge clk);
    start = 1'b0; a_in = 6'd1; b_in = 6'd1;
    count_dones(12, dcnt, dfirst, dlast);
    check("t4_done_count", dcnt, 1);
    check("t4_product", 32'(product), 81);

    // Asynchronous reset during the third iteration
    @(negedge clk);
    start = 1'b1; a_in = 6'd20; b_in = 6'd20;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_abort_busy", 32'(busy), 0);
    check("t5_abort_done", 32'(done), 0);
    check("t5_abort_product", 32'(product), 0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(10, dcnt, dfirst, dlast);
    check("t5_no_done_after_abort", dcnt, 0);
    check("t5_product_still_zero", 32'(product), 0);
    run_op(6'd20, 6'd20, "t5_20x20");

    // Operand sweep
    for (int i = 0; i < 200; i++) begin
      run_op(N'($urandom_range(0, 63)), N'($urandom_range(0, 63)), "t6_sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
